// File: rtl/fixed3_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fixed3_alu_pkg
//  Purpose  : Shared definitions for the Fixed3 vector ALU pipeline.
//             - Fixed scalar format (FIXED_W total bits, FRAC_W fraction bits,
//               two's complement, 1.0 = 1 << FRAC_W)
//             - Fixed3 packing: Dim[0] in the LSBs, Dim[2] in the MSBs
//             - opcode encoding (5..7 reserved)
//             - saturation limits for the default scalar width
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fixed3_alu_pkg;

    localparam int FIXED_W = 32;
    localparam int FRAC_W  = 16;
    localparam int DIMS    = 3;

    typedef logic signed [FIXED_W-1:0]      fixed_t;
    // Fixed3 word: {Dim[2], Dim[1], Dim[0]}
    typedef logic        [DIMS*FIXED_W-1:0] fixed3_t;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_SCALE = 3'd2,
        OP_DOT   = 3'd3,
        OP_CROSS = 3'd4
    } alu_op_e;

    localparam fixed_t c_fixed_max = {1'b0, {(FIXED_W-1){1'b1}}};
    localparam fixed_t c_fixed_min = {1'b1, {(FIXED_W-1){1'b0}}};

endpackage : fixed3_alu_pkg
`default_nettype wire

// File: rtl/fixed_mul_sh.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_mul_sh
//  Purpose  : Combinational fixed-point multiply. Forms the full 2*W signed
//             product, arithmetic-shifts it right by FRAC (round toward -inf)
//             and reduces it to W bits, either by wrapping or, when the
//             FIXED3_ALU_SAT_EN macro is defined, by clamping to the W-bit
//             signed range.
//  Ports    : i_a, i_b  W-bit signed operands
//             o_p       W-bit result
//             o_sat     1 when the result was clamped (always 0 when wrapping)
//  Config   : FIXED3_ALU_SAT_EN - saturate instead of wrap
//  Revision : 1.0 - initial release
// ============================================================================
module fixed_mul_sh
    import fixed3_alu_pkg::*;
#(
    parameter int W    = fixed3_alu_pkg::FIXED_W,
    parameter int FRAC = fixed3_alu_pkg::FRAC_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_p,
    output logic         o_sat
);

`ifdef FIXED3_ALU_SAT_EN
    localparam bit c_sat_en = 1'b1;
`else
    localparam bit c_sat_en = 1'b0;
`endif

    localparam logic [W-1:0] c_max = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] c_min = {1'b1, {(W-1){1'b0}}};

    logic signed [2*W-1:0] w_prod;
    logic signed [2*W-1:0] w_shift;
    logic                  w_ovf;

    assign w_prod  = $signed({{W{i_a[W-1]}}, i_a}) * $signed({{W{i_b[W-1]}}, i_b});
    assign w_shift = w_prod >>> FRAC;

    // The shifted value fits in W bits only if bits [2W-1:W-1] are all copies
    // of the sign bit.
    assign w_ovf = !((&w_shift[2*W-1:W-1]) || !(|w_shift[2*W-1:W-1]));

    always_comb begin
        o_p   = w_shift[W-1:0];
        o_sat = 1'b0;
        if (c_sat_en && w_ovf) begin
            o_p   = w_shift[2*W-1] ? c_min : c_max;
            o_sat = 1'b1;
        end
    end

endmodule : fixed_mul_sh
`default_nettype wire

// File: rtl/fixed3_vec_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fixed3_vec_alu_pipe
//  Purpose  : 3-stage, throughput-1 Fixed3 vector ALU (ADD, SUB, SCALE, DOT,
//             CROSS) with valid/ready handshakes and a pass-through tag.
//             S1: register operands / all products (6 shared multipliers)
//             S2: per-dim add/sub, or DOT partial sum p0+p1
//             S3: final DOT add, result mux, output register
//  Ports    : clk, reset            clock, synchronous active-high reset
//             in_valid/in_ready     input handshake
//             in_op, in_a, in_b,    operation, Fixed3 operands, SCALE factor,
//             in_f, in_tag          user tag
//             out_valid/out_ready   output handshake
//             out_v, out_tag        Fixed3 result and its tag
//             out_err               reserved opcode (result forced to zero)
//             out_sat               any saturation in result (macro only)
//             busy                  any stage holds an operation
//  Config   : FIXED3_ALU_SAT_EN - saturating arithmetic and out_sat port
//  Revision : 1.0 - initial release
// ============================================================================
module fixed3_vec_alu_pipe
    import fixed3_alu_pkg::*;
#(
    parameter int FIXED_W = fixed3_alu_pkg::FIXED_W,
    parameter int FRAC_W  = fixed3_alu_pkg::FRAC_W,
    parameter int TAG_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [3*FIXED_W-1:0] in_a,
    input  logic [3*FIXED_W-1:0] in_b,
    input  logic [FIXED_W-1:0]   in_f,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*FIXED_W-1:0] out_v,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err,
`ifdef FIXED3_ALU_SAT_EN
    output logic                 out_sat,
`endif
    output logic                 busy
);

`ifdef FIXED3_ALU_SAT_EN
    localparam bit c_sat_en = 1'b1;
`else
    localparam bit c_sat_en = 1'b0;
`endif

    localparam logic [FIXED_W-1:0] c_max = {1'b0, {(FIXED_W-1){1'b1}}};
    localparam logic [FIXED_W-1:0] c_min = {1'b1, {(FIXED_W-1){1'b0}}};

    // Returns {saturated, result}; wraps unless saturation is enabled.
    function automatic logic [FIXED_W:0] f_addsub(input logic [FIXED_W-1:0] x,
                                                  input logic [FIXED_W-1:0] y,
                                                  input logic               sub);
        logic [FIXED_W:0]   ext;
        logic [FIXED_W-1:0] res;
        logic               ovf;
        ext = sub ? ({x[FIXED_W-1], x} - {y[FIXED_W-1], y})
                  : ({x[FIXED_W-1], x} + {y[FIXED_W-1], y});
        ovf = ext[FIXED_W] ^ ext[FIXED_W-1];
        res = ext[FIXED_W-1:0];
        if (c_sat_en && ovf) begin
            res = ext[FIXED_W] ? c_min : c_max;
        end
        return {c_sat_en && ovf, res};
    endfunction

    // ------------------------------------------------------------------------
    // Handshake: a stage loads when empty or when its successor loads.
    // ------------------------------------------------------------------------
    logic r_s1_valid, r_s2_valid, r_s3_valid;
    logic w_s1_load, w_s2_load, w_s3_load;

    assign w_s3_load = !r_s3_valid || out_ready;
    assign w_s2_load = !r_s2_valid || w_s3_load;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;
    assign busy      = r_s1_valid || r_s2_valid || r_s3_valid;

    // ------------------------------------------------------------------------
    // S1 input side: operand unpack, multiplier operand selection
    // ------------------------------------------------------------------------
    logic [FIXED_W-1:0] w_a  [3];
    logic [FIXED_W-1:0] w_b  [3];
    logic [FIXED_W-1:0] w_mx [6];
    logic [FIXED_W-1:0] w_my [6];
    logic [FIXED_W-1:0] w_p  [6];
    logic [5:0]         w_psat;
    logic [FIXED_W-1:0] w_s1_x [6];
    logic               w_s1_sat;

    always_comb begin
        for (int d = 0; d < 3; d++) begin
            w_a[d] = in_a[d*FIXED_W +: FIXED_W];
            w_b[d] = in_b[d*FIXED_W +: FIXED_W];
        end
    end

    // Units 0-2 serve DOT/SCALE per dim and the first three CROSS terms;
    // units 3-5 are hardwired to the remaining CROSS terms.
    always_comb begin
        for (int d = 0; d < 3; d++) begin
            w_mx[d] = w_a[d];
            w_my[d] = (in_op == OP_SCALE) ? in_f : w_b[d];
        end
        if (in_op == OP_CROSS) begin
            w_mx[0] = w_a[1]; w_my[0] = w_b[2];
            w_mx[1] = w_a[2]; w_my[1] = w_b[1];
            w_mx[2] = w_a[2]; w_my[2] = w_b[0];
        end
        w_mx[3] = w_a[0]; w_my[3] = w_b[2];
        w_mx[4] = w_a[0]; w_my[4] = w_b[1];
        w_mx[5] = w_a[1]; w_my[5] = w_b[0];
    end

    for (genvar i = 0; i < 6; i++) begin : g_mul
        fixed_mul_sh #(
            .W    (FIXED_W),
            .FRAC (FRAC_W)
        ) u_mul (
            .i_a   (w_mx[i]),
            .i_b   (w_my[i]),
            .o_p   (w_p[i]),
            .o_sat (w_psat[i])
        );
    end

    // ADD/SUB carry raw operands in the product slots: a in 0-2, b in 3-5.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_s1_x[i] = w_p[i];
        end
        w_s1_sat = 1'b0;
        case (in_op)
            OP_ADD, OP_SUB: begin
                for (int d = 0; d < 3; d++) begin
                    w_s1_x[d]   = w_a[d];
                    w_s1_x[d+3] = w_b[d];
                end
            end
            OP_SCALE, OP_DOT: w_s1_sat = |w_psat[2:0];
            OP_CROSS:         w_s1_sat = |w_psat;
            default:          w_s1_sat = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // S1 registers
    // ------------------------------------------------------------------------
    logic [2:0]         r_s1_op;
    logic [TAG_W-1:0]   r_s1_tag;
    logic [FIXED_W-1:0] r_s1_x [6];
    logic               r_s1_sat;

    always_ff @(posedge clk) begin
        if (w_s1_load && in_valid) begin
            r_s1_op  <= in_op;
            r_s1_tag <= in_tag;
            r_s1_sat <= w_s1_sat;
            for (int i = 0; i < 6; i++) begin
                r_s1_x[i] <= w_s1_x[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // S2: sums and differences
    // ------------------------------------------------------------------------
    logic [FIXED_W-1:0] w_s2_v [3];
    logic               w_s2_sat;

    always_comb begin
        logic [FIXED_W:0] t;
        t = '0;
        for (int d = 0; d < 3; d++) begin
            w_s2_v[d] = r_s1_x[d];
        end
        w_s2_sat = r_s1_sat;
        case (r_s1_op)
            OP_ADD, OP_SUB: begin
                for (int d = 0; d < 3; d++) begin
                    t         = f_addsub(r_s1_x[d], r_s1_x[d+3], r_s1_op == OP_SUB);
                    w_s2_v[d] = t[FIXED_W-1:0];
                    w_s2_sat  = w_s2_sat | t[FIXED_W];
                end
            end
            OP_CROSS: begin
                for (int d = 0; d < 3; d++) begin
                    t         = f_addsub(r_s1_x[2*d], r_s1_x[2*d+1], 1'b1);
                    w_s2_v[d] = t[FIXED_W-1:0];
                    w_s2_sat  = w_s2_sat | t[FIXED_W];
                end
            end
            OP_DOT: begin
                // Dim0 carries p0+p1, Dim1 carries p2 on to S3.
                t         = f_addsub(r_s1_x[0], r_s1_x[1], 1'b0);
                w_s2_v[0] = t[FIXED_W-1:0];
                w_s2_v[1] = r_s1_x[2];
                w_s2_v[2] = '0;
                w_s2_sat  = w_s2_sat | t[FIXED_W];
            end
            default: ;
        endcase
    end

    logic [2:0]         r_s2_op;
    logic [TAG_W-1:0]   r_s2_tag;
    logic [FIXED_W-1:0] r_s2_v [3];
    logic               r_s2_sat;

    always_ff @(posedge clk) begin
        if (w_s2_load && r_s1_valid) begin
            r_s2_op  <= r_s1_op;
            r_s2_tag <= r_s1_tag;
            r_s2_sat <= w_s2_sat;
            for (int d = 0; d < 3; d++) begin
                r_s2_v[d] <= w_s2_v[d];
            end
        end
    end

    // ------------------------------------------------------------------------
    // S3: final DOT add and result mux
    // ------------------------------------------------------------------------
    logic [3*FIXED_W-1:0] w_s3_vec;
    logic                 w_s3_err;
    logic                 w_s3_sat;

    always_comb begin
        logic [FIXED_W:0] t;
        t        = '0;
        w_s3_vec = {r_s2_v[2], r_s2_v[1], r_s2_v[0]};
        w_s3_err = 1'b0;
        w_s3_sat = r_s2_sat;
        case (r_s2_op)
            OP_ADD, OP_SUB, OP_SCALE, OP_CROSS: ;
            OP_DOT: begin
                t        = f_addsub(r_s2_v[0], r_s2_v[1], 1'b0);
                w_s3_vec = {{(2*FIXED_W){1'b0}}, t[FIXED_W-1:0]};
                w_s3_sat = w_s3_sat | t[FIXED_W];
            end
            default: begin
                w_s3_vec = '0;
                w_s3_err = 1'b1;
                w_s3_sat = 1'b0;
            end
        endcase
    end

    logic [3*FIXED_W-1:0] r_out_v;
    logic [TAG_W-1:0]     r_out_tag;
    logic                 r_out_err;
    logic                 r_out_sat;

    always_ff @(posedge clk) begin
        if (w_s3_load && r_s2_valid) begin
            r_out_v   <= w_s3_vec;
            r_out_tag <= r_s2_tag;
        end
    end

    // Valids and status flags are the only reset state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_out_err  <= 1'b0;
            r_out_sat  <= 1'b0;
        end else begin
            if (w_s1_load) r_s1_valid <= in_valid;
            if (w_s2_load) r_s2_valid <= r_s1_valid;
            if (w_s3_load) begin
                r_s3_valid <= r_s2_valid;
                r_out_err  <= r_s2_valid && w_s3_err;
                r_out_sat  <= r_s2_valid && w_s3_sat;
            end
        end
    end

    assign out_valid = r_s3_valid;
    assign out_v     = r_out_v;
    assign out_tag   = r_out_tag;
    assign out_err   = r_out_err;
`ifdef FIXED3_ALU_SAT_EN
    assign out_sat   = r_out_sat;
`endif

endmodule : fixed3_vec_alu_pipe
`default_nettype wire

// File: tb/tb_fixed3_vec_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fixed3_vec_alu_pipe
//  Purpose  : Directed self-checking bench for fixed3_vec_alu_pipe.
//  Config   : FIXED3_ALU_SAT_EN - expects saturating results and out_sat
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fixed3_vec_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [95:0] in_a, in_b;
    logic [31:0] in_f;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_v;
    logic [7:0]  out_tag;
    logic        out_err;
`ifdef FIXED3_ALU_SAT_EN
    logic        out_sat;
`endif
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fixed3_vec_alu_pipe #(
        .FIXED_W (32),
        .FRAC_W  (16),
        .TAG_W   (8)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_f      (in_f),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_v     (out_v),
        .out_tag   (out_tag),
        .out_err   (out_err),
`ifdef FIXED3_ALU_SAT_EN
        .out_sat   (out_sat),
`endif
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Integer-valued Fixed3 word, Dim[0] in LSBs.
    function automatic logic [95:0] pack3(input int x0, input int x1, input int x2);
        logic [31:0] d0, d1, d2;
        d0 = 32'(x0 <<< 16);
        d1 = 32'(x1 <<< 16);
        d2 = 32'(x2 <<< 16);
        return {d2, d1, d0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [95:0] a, input logic [95:0] b,
                         input logic [31:0] f, input logic [7:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_f     = f;
        in_tag   = tag;
    endtask

    initial begin
        int          sent, rcvd, stray;
        bit          held, saw_stall;
        logic [95:0] held_v;
        logic [7:0]  held_tag;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_f      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_err", out_err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 1);

        // DOT latency and value
        drive(3'd3, pack3(1, 2, 3), pack3(4, 5, 6), 32'h0, 8'h11);
        step();
        in_valid = 1'b0;
        check_eq("dot_lat1", out_valid, 0);
        step();
        check_eq("dot_lat2", out_valid, 0);
        step();
        check_eq("dot_valid", out_valid, 1);
        check_eq("dot_v", out_v, {64'h0, 32'h0020_0000});
        check_eq("dot_tag", out_tag, 8'h11);
`ifdef FIXED3_ALU_SAT_EN
        check_eq("dot_sat", out_sat, 0);
`endif
        step();

        // CROSS then SCALE back to back
        drive(3'd4, pack3(1, 0, 0), pack3(0, 1, 0), 32'h0, 8'h21);
        step();
        drive(3'd2, pack3(2, -4, 6), 96'h0, 32'h0000_8000, 8'h22);
        step();
        in_valid = 1'b0;
        step();
        check_eq("cross_valid", out_valid, 1);
        check_eq("cross_v", out_v, pack3(0, 0, 1));
        check_eq("cross_tag", out_tag, 8'h21);
        step();
        check_eq("scale_valid", out_valid, 1);
        check_eq("scale_v", out_v, pack3(1, -2, 3));
        check_eq("scale_tag", out_tag, 8'h22);
        step();

        // Overflow on ADD
        drive(3'd0, {64'h0, 32'h7FFF_0000}, {64'h0, 32'h0002_0000}, 32'h0, 8'h31);
        step();
        in_valid = 1'b0;
        step();
        step();
        check_eq("ovf_valid", out_valid, 1);
`ifdef FIXED3_ALU_SAT_EN
        check_eq("ovf_v", out_v, {64'h0, 32'h7FFF_FFFF});
        check_eq("ovf_sat", out_sat, 1);
`else
        check_eq("ovf_v", out_v, {64'h0, 32'h8001_0000});
`endif
        step();

        // Reserved opcode followed by ADD
        drive(3'd6, pack3(7, 7, 7), pack3(9, 9, 9), 32'h0001_0000, 8'h41);
        step();
        drive(3'd0, pack3(1, 2, 3), pack3(1, 1, 1), 32'h0, 8'h42);
        step();
        in_valid = 1'b0;
        step();
        check_eq("rsv_valid", out_valid, 1);
        check_eq("rsv_v", out_v, 96'h0);
        check_eq("rsv_err", out_err, 1);
        check_eq("rsv_tag", out_tag, 8'h41);
        step();
        check_eq("add_valid", out_valid, 1);
        check_eq("add_err", out_err, 0);
        check_eq("add_v", out_v, pack3(2, 3, 4));
        check_eq("add_tag", out_tag, 8'h42);
        step();
        check_eq("drain_busy", busy, 0);

        // Backpressure stream: ADD on even tags, SUB on odd tags
        sent      = 0;
        rcvd      = 0;
        held      = 1'b0;
        saw_stall = 1'b0;
        held_v    = '0;
        held_tag  = '0;
        for (int cyc = 0; cyc < 200 && rcvd < 10; cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (sent < 10) begin
                drive((sent % 2 == 1) ? 3'd1 : 3'd0, pack3(sent, sent, sent), pack3(1, 2, 3),
                      32'h0, 8'(sent));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_v", out_v, held_v);
                check_eq("hold_tag", out_tag, held_tag);
            end
            if (!in_ready) begin
                saw_stall = 1'b1;
            end
            if (out_valid && out_ready) begin
                check_eq("bp_tag", out_tag, 8'(rcvd));
                if (rcvd % 2 == 1) begin
                    check_eq("bp_v", out_v, pack3(rcvd - 1, rcvd - 2, rcvd - 3));
                end else begin
                    check_eq("bp_v", out_v, pack3(rcvd + 1, rcvd + 2, rcvd + 3));
                end
                rcvd++;
            end
            held     = out_valid && !out_ready;
            held_v   = out_v;
            held_tag = out_tag;
            if (in_valid && in_ready) begin
                sent++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("bp_count", 96'(rcvd), 96'd10);
        check_eq("bp_in_ready_dropped", saw_stall, 1);

        // Reset with three ops in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'd0, pack3(i, i, i), pack3(1, 1, 1), 32'h0, 8'(8'h50 + i));
            step();
        end
        in_valid = 1'b0;
        check_eq("full_busy", busy, 1);
        check_eq("full_in_ready", in_ready, 0);
        reset = 1'b1;
        step();
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_busy", busy, 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        stray     = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) begin
                stray++;
            end
        end
        check_eq("midrst_no_stale", 96'(stray), 96'd0);
        check_eq("midrst_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fixed3_vec_alu_pipe
`default_nettype wire

// File: doc/fixed3_vec_alu_pipe.md
Name: fixed3_vec_alu_pipe

Overview:
- 3-stage pipelined vector ALU on Fixed3 operands: ADD, SUB, SCALE, DOT, CROSS.
- Sits between the ray-setup stage and the intersection stages.
- Gives one shared, throughput-1 datapath in place of per-stage combinational Fixed3 math.
- valid/ready on both sides; an opaque tag travels with each operation.

Parameters:
- FIXED_W, 32, total bits of one Fixed scalar (two's complement).
- FRAC_W, 16, fractional bits; 1.0 = 1<<FRAC_W.
- TAG_W, 8, width of the pass-through tag.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid & in_ready.
- in_op  in  3  0=ADD, 1=SUB, 2=SCALE, 3=DOT, 4=CROSS; 5-7 reserved.
- in_a  in  3*FIXED_W  Fixed3 operand A; Dim[0] in LSBs.
- in_b  in  3*FIXED_W  Fixed3 operand B.
- in_f  in  FIXED_W  scalar for SCALE.
- in_tag  in  TAG_W  user tag.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_v  out  3*FIXED_W  Fixed3 result. DOT puts its scalar in Dim[0] and forces Dim[1..2] to 0.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  reserved opcode was issued; result is all zero.
- busy  out  1  any stage valid.

Behaviour:
- Stages:
  - S1 registers the operands and forms all products: 3 for SCALE/DOT, 6 for CROSS.
  - S2 forms sums/differences: per-dim for ADD/SUB/CROSS, partial sum p0+p1 for DOT.
  - S3 does the final DOT add (S2 sum + p2), muxes the result and registers the output.
- Latency: 3 cycles from accept to out_valid with no stalls. Throughput is 1 op/cycle.
- Stall rule: stage k loads when it is empty or stage k+1 loads (S3 loads when it is empty or out_ready).
- in_ready = S1 empty or S1 advances. in_ready may depend combinationally on out_ready. There is no combinational path from in_* to out_*.
- out_* hold stable while out_valid & !out_ready.
- Mul: 2*FIXED_W signed product, arithmetic shift right by FRAC_W (rounding toward -inf), then truncate to FIXED_W (wrap).
- Add/Sub: FIXED_W wrap-around.
- CROSS: Dim0 = a1*b2 - a2*b1, Dim1 = a2*b0 - a0*b2, Dim2 = a0*b1 - a1*b0. Each product is shifted before the subtract.
- Reserved op: accepted normally; result 0 with out_err=1 for that beat only.
- Reset: clears all stage valids. out_valid=0, out_err=0, busy=0, in_ready=1 the cycle after reset deasserts. Data regs may be left unreset.
- Reset mid-operation discards in-flight ops; nothing is emitted for them.
- Simultaneous accept and emit with the pipe full keeps it full with no bubble.
- Ordering is strictly in-order. Tags are never reordered or duplicated.

Optional Feature:
- Macro FIXED3_ALU_SAT_EN.
- Defined: every mul, add and sub saturates to the most positive / most negative FIXED_W value instead of wrapping. Saturation is checked per operation, including each intermediate DOT and CROSS step.
- Defined: extra port out_sat (out, 1) is 1 when any saturation occurred in that result.
- Undefined: wrap-around arithmetic and no out_sat port.

Decomposition:
- Shared package fixed3_alu_pkg holds:
  - opcode enum (ADD, SUB, SCALE, DOT, CROSS);
  - FIXED_W/FRAC_W localparams shared with the Fixed scalar type;
  - the Fixed3 packing order (Dim[0] at LSBs);
  - saturation min/max constants.
- One sub-module: fixed_mul_sh. It is combinational: signed multiply, shift, wrap or saturate, plus a sat flag. It is instantiated 6 times in S1.
- Stage registers and the handshake stay in the top module.

Test Plan:
- DOT, a=(1.0,2.0,3.0), b=(4.0,5.0,6.0) (0x10000 units), out_ready=1 -> after exactly 3 cycles out_v Dim0=32.0 (0x200000), Dim1=Dim2=0, tag echoed.
- CROSS, a=(1,0,0), b=(0,1,0) -> (0,0,1.0). Back-to-back with SCALE f=0.5 (0x8000), a=(2,-4,6) -> (1.0,-2.0,3.0). Both results appear on consecutive cycles.
- Backpressure: stream 10 ops with tags 0..9 while out_ready toggles 1,0,0,1 repeating.
  - All 10 tags arrive in order with no loss or duplication.
  - out_v stays stable while stalled.
  - in_ready drops once 3 ops are held.
- Overflow: ADD a0=0x7FFF0000, b0=0x00020000.
  - Without the macro -> 0x80010000.
  - With FIXED3_ALU_SAT_EN -> 0x7FFFFFFF and out_sat=1.
- Reserved op 6 -> out_v=0, out_err=1 on that beat only. The following ADD has out_err=0.
- Assert reset while 3 ops are in flight -> next cycle out_valid=0 and busy=0. No stale result is emitted after reset releases.
